// File: rtl/mouse_packet_tracker.sv
// Mouse packet tracker: turns a PS/2 mouse byte stream into a
// clamped cursor position plus button state.
module mouse_packet_tracker #(
  parameter int SCREEN_W       = 320,
  parameter int SCREEN_H       = 240,
  parameter int X_W            = 9,
  parameter int Y_W            = 8,
  parameter int START_X        = 160,
  parameter int START_Y        = 120,
  parameter int SKIP_BYTES     = 2,
  parameter int SENS_SHIFT     = 0,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           byte_valid,
  input  logic [7:0]     byte_data,
  output logic [X_W-1:0] x_position,
  output logic [Y_W-1:0] y_position,
  output logic           left_button,
  output logic           right_button,
  output logic           middle_button,
  output logic           packet_valid,
  output logic           sync_error
);

  localparam int MW  = (X_W > Y_W) ? X_W : Y_W;
  localparam int SW  = ((MW > 9) ? MW : 9) + 2;
  localparam int SKW = (SKIP_BYTES > 1) ? $clog2(SKIP_BYTES) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [SKW-1:0] SKIP_LAST =
    SKW'((SKIP_BYTES > 0) ? SKIP_BYTES - 1 : 0);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

  localparam logic signed [SW-1:0] X_MAX = SW'(SCREEN_W - 1);
  localparam logic signed [SW-1:0] Y_MAX = SW'(SCREEN_H - 1);

  typedef enum logic [1:0] {
    SKIP,
    B0,
    B1,
    B2
  } state_t;

  localparam state_t RST_STATE = (SKIP_BYTES == 0) ? B0 : SKIP;

  state_t state;
  state_t state_nx;
  state_t eff;

  logic [SKW-1:0] skip_cnt;
  logic [TW-1:0]  to_cnt;

  logic timeout;
  logic skip_byte;
  logic take_b0;
  logic take_b1;
  logic take_b2;
  logic bad_b0;

  logic       b0_xs;
  logic       b0_ys;
  logic       b0_xo;
  logic       b0_yo;
  logic [2:0] b0_btn;
  logic [7:0] x_lo;

  logic signed [8:0]    dx_raw;
  logic signed [8:0]    dy_raw;
  logic signed [8:0]    dx_sh;
  logic signed [8:0]    dy_sh;
  logic signed [SW-1:0] dx;
  logic signed [SW-1:0] dy;
  logic signed [SW-1:0] sum_x;
  logic signed [SW-1:0] sum_y;
  logic [X_W-1:0]       new_x;
  logic [Y_W-1:0]       new_y;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RST_STATE;
    end else begin
      state <= state_nx;
    end
  end

  // A timeout drops back to B0 in the same cycle, so a byte
  // landing on that cycle is decoded as a byte-0 candidate.
  always_comb begin
    timeout   = ((state == B1) || (state == B2))
                && (to_cnt == TO_MAX);
    eff       = timeout ? B0 : state;
    state_nx  = eff;
    skip_byte = 1'b0;
    take_b0   = 1'b0;
    take_b1   = 1'b0;
    take_b2   = 1'b0;
    bad_b0    = 1'b0;
    if (byte_valid) begin
      unique case (eff)
        SKIP: begin
          skip_byte = 1'b1;
          if (skip_cnt == SKIP_LAST) begin
            state_nx = B0;
          end
        end
        B0: begin
          if (byte_data[3]) begin
            take_b0  = 1'b1;
            state_nx = B1;
          end else begin
            bad_b0 = 1'b1;
          end
        end
        B1: begin
          take_b1  = 1'b1;
          state_nx = B2;
        end
        B2: begin
          take_b2  = 1'b1;
          state_nx = B0;
        end
        default: begin
          state_nx = B0;
        end
      endcase
    end
  end

  // Wide signed sums keep the clamp free of wraparound.
  always_comb begin
    dx_raw = {b0_xs, x_lo};
    dy_raw = {b0_ys, byte_data};
    dx_sh  = dx_raw >>> SENS_SHIFT;
    dy_sh  = dy_raw >>> SENS_SHIFT;
    dx     = b0_xo ? '0 : SW'(dx_sh);
    dy     = b0_yo ? '0 : SW'(dy_sh);
    sum_x  = $signed(SW'(x_position)) + dx;
    sum_y  = $signed(SW'(y_position)) - dy;

    if (sum_x < 0) begin
      new_x = '0;
    end else if (sum_x > X_MAX) begin
      new_x = X_W'(SCREEN_W - 1);
    end else begin
      new_x = sum_x[X_W-1:0];
    end

    if (sum_y < 0) begin
      new_y = '0;
    end else if (sum_y > Y_MAX) begin
      new_y = Y_W'(SCREEN_H - 1);
    end else begin
      new_y = sum_y[Y_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      skip_cnt      <= '0;
      to_cnt        <= '0;
      b0_xs         <= 1'b0;
      b0_ys         <= 1'b0;
      b0_xo         <= 1'b0;
      b0_yo         <= 1'b0;
      b0_btn        <= '0;
      x_lo          <= '0;
      x_position    <= X_W'(START_X);
      y_position    <= Y_W'(START_Y);
      left_button   <= 1'b0;
      right_button  <= 1'b0;
      middle_button <= 1'b0;
      packet_valid  <= 1'b0;
      sync_error    <= 1'b0;
    end else begin
      packet_valid <= take_b2;
      sync_error   <= bad_b0;

      if (skip_byte) begin
        skip_cnt <= skip_cnt + SKW'(1);
      end

      if (byte_valid || timeout) begin
        to_cnt <= '0;
      end else if ((state == B1) || (state == B2)) begin
        to_cnt <= to_cnt + TW'(1);
      end

      if (take_b0) begin
        b0_btn <= byte_data[2:0];
        b0_xs  <= byte_data[4];
        b0_ys  <= byte_data[5];
        b0_xo  <= byte_data[6];
        b0_yo  <= byte_data[7];
      end

      if (take_b1) begin
        x_lo <= byte_data;
      end

      if (take_b2) begin
        x_position    <= new_x;
        y_position    <= new_y;
        left_button   <= b0_btn[0];
        right_button  <= b0_btn[1];
        middle_button <= b0_btn[2];
      end
    end
  end

endmodule

// File: tb/tb_mouse_packet_tracker.sv
// Bench for mouse_packet_tracker: directed cases plus a random
// byte stream checked against a packet-level reference model.
module tb_mouse_packet_tracker;

  localparam int T   = 64;
  localparam int SW_ = 320;
  localparam int SH_ = 240;
  localparam int SH  = 0;

  logic       clk;
  logic       reset;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic [8:0] x_position;
  logic [7:0] y_position;
  logic       left_button;
  logic       right_button;
  logic       middle_button;
  logic       packet_valid;
  logic       sync_error;

  logic       bv2;
  logic [7:0] bd2;
  logic [8:0] x2;
  logic [7:0] y2;
  logic       l2;
  logic       r2;
  logic       m2;
  logic       pv2;
  logic       se2;

  mouse_packet_tracker #(
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .x_position   (x_position),
    .y_position   (y_position),
    .left_button  (left_button),
    .right_button (right_button),
    .middle_button(middle_button),
    .packet_valid (packet_valid),
    .sync_error   (sync_error)
  );

  mouse_packet_tracker #(
    .SKIP_BYTES    (0),
    .SENS_SHIFT    (1),
    .TIMEOUT_CYCLES(T)
  ) dut2 (
    .clk          (clk),
    .reset        (reset),
    .byte_valid   (bv2),
    .byte_data    (bd2),
    .x_position   (x2),
    .y_position   (y2),
    .left_button  (l2),
    .right_button (r2),
    .middle_button(m2),
    .packet_valid (pv2),
    .sync_error   (se2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int         mx;
  int         my;
  logic [2:0] mbtn;
  int         phase;
  int         skip_left;
  int         idle;
  logic [7:0] p0;
  logic [7:0] p1;
  logic       exp_pv;
  logic       exp_se;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clampi(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int delta(logic [7:0] lo, logic sgn, logic ovf);
    int v;
    if (ovf) return 0;
    v = sgn ? int'(lo) - 256 : int'(lo);
    return v >>> SH;
  endfunction

  task automatic model_reset();
    mx        = 160;
    my        = 120;
    mbtn      = 3'b000;
    phase     = 0;
    skip_left = 2;
    idle      = 0;
    exp_pv    = 1'b0;
    exp_se    = 1'b0;
  endtask

  task automatic model_edge(input bit v, input logic [7:0] d);
    exp_pv = 1'b0;
    exp_se = 1'b0;
    if (!v) begin
      idle++;
    end else begin
      if (phase != 0 && idle >= T) phase = 0;
      idle = 0;
      if (skip_left > 0) begin
        skip_left--;
      end else if (phase == 0) begin
        if (d[3]) begin
          p0    = d;
          phase = 1;
        end else begin
          exp_se = 1'b1;
        end
      end else if (phase == 1) begin
        p1    = d;
        phase = 2;
      end else begin
        mx     = clampi(mx + delta(p1, p0[4], p0[6]), 0, SW_ - 1);
        my     = clampi(my - delta(d, p0[5], p0[7]), 0, SH_ - 1);
        mbtn   = p0[2:0];
        exp_pv = 1'b1;
        phase  = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("x", 32'(x_position), mx);
    chk("y", 32'(y_position), my);
    chk("btn", 32'({middle_button, right_button, left_button}),
        32'(mbtn));
    chk("packet_valid", 32'(packet_valid), 32'(exp_pv));
    chk("sync_error", 32'(sync_error), 32'(exp_se));
  endtask

  task automatic step(input bit v, input logic [7:0] d);
    byte_valid = v;
    byte_data  = d;
    @(posedge clk);
    model_edge(v, d);
    #1;
    check_all();
    byte_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input int gap);
    repeat (gap) step(1'b0, 8'($urandom));
    step(1'b1, d);
  endtask

  task automatic idle_n(input int n);
    repeat (n) step(1'b0, 8'($urandom));
  endtask

  task automatic do_reset(input bit v);
    reset      = 1'b1;
    byte_valid = v;
    byte_data  = 8'h08;
    @(posedge clk);
    model_reset();
    #1;
    check_all();
    reset      = 1'b0;
    byte_valid = 1'b0;
  endtask

  task automatic skip2();
    send(8'hFA, 0);
    send(8'hAA, 0);
  endtask

  task automatic pkt(input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] c);
    send(a, 0);
    send(b, 0);
    send(c, 0);
  endtask

  task automatic step2(input logic [7:0] d);
    bv2 = 1'b1;
    bd2 = d;
    step(1'b0, 8'h00);
    bv2 = 1'b0;
  endtask

  initial begin
    int n;
    int r;
    logic [7:0] b;
    reset      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    bv2        = 1'b0;
    bd2        = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    do_reset(1'b0);
    chk("rst_x", 32'(x_position), 160);
    chk("rst_y", 32'(y_position), 120);
    chk("rst_pv", 32'(packet_valid), 0);

    send(8'hFA, 0);
    send(8'hAA, 0);
    pkt(8'h09, 8'h05, 8'h03);
    chk("basic_x", 32'(x_position), 165);
    chk("basic_y", 32'(y_position), 117);
    chk("basic_left", 32'(left_button), 1);
    chk("basic_pv", 32'(packet_valid), 1);
    idle_n(1);
    chk("basic_pv_once", 32'(packet_valid), 0);

    do_reset(1'b1);
    skip2();
    pkt(8'h38, 8'hF6, 8'hFB);
    chk("neg_x", 32'(x_position), 150);
    chk("neg_y", 32'(y_position), 125);
    chk("neg_btn", 32'({middle_button, right_button, left_button}), 0);

    do_reset(1'b0);
    skip2();
    pkt(8'h08, 8'h7F, 8'h00);
    chk("clamp_x1", 32'(x_position), 287);
    pkt(8'h08, 8'h7F, 8'h00);
    chk("clamp_x2", 32'(x_position), 319);
    repeat (3) pkt(8'h18, 8'h80, 8'h00);
    chk("clamp_x0", 32'(x_position), 0);
    repeat (3) pkt(8'h18, 8'h80, 8'h00);
    chk("clamp_x0_hold", 32'(x_position), 0);

    do_reset(1'b0);
    skip2();
    send(8'h00, 0);
    chk("sync_err", 32'(sync_error), 1);
    pkt(8'h08, 8'h02, 8'h00);
    chk("resync_x", 32'(x_position), 162);

    do_reset(1'b0);
    skip2();
    send(8'h08, 0);
    send(8'h05, 0);
    idle_n(T);
    pkt(8'h08, 8'h02, 8'h00);
    chk("timeout_x", 32'(x_position), 162);

    do_reset(1'b0);
    skip2();
    send(8'h08, 0);
    send(8'h05, 0);
    idle_n(T - 1);
    send(8'h08, 0);
    chk("no_timeout_x", 32'(x_position), 165);
    chk("no_timeout_y", 32'(y_position), 112);

    do_reset(1'b0);
    skip2();
    pkt(8'h48, 8'hFF, 8'h04);
    chk("ovf_x", 32'(x_position), 160);
    chk("ovf_y", 32'(y_position), 116);

    do_reset(1'b0);
    skip2();
    send(8'h08, 0);
    send(8'h05, 0);
    do_reset(1'b0);
    skip2();
    pkt(8'h08, 8'h02, 8'h00);
    chk("mid_reset_x", 32'(x_position), 162);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        do_reset(1'($urandom_range(0, 1)));
      end else if (r < 10) begin
        send(8'($urandom), $urandom_range(0, 3));
      end else if (r < 14) begin
        n = T - 1 + $urandom_range(0, 2);
        idle_n(n);
      end else begin
        b = 8'($urandom) | 8'h08;
        send(b, $urandom_range(0, 3));
        send(8'($urandom), $urandom_range(0, 3));
        send(8'($urandom), $urandom_range(0, 3));
      end
    end

    do_reset(1'b0);
    step2(8'h08);
    step2(8'h10);
    step2(8'h00);
    chk("sens_x", 32'(x2), 168);
    chk("sens_pv", 32'(pv2), 1);
    step2(8'h18);
    step2(8'hFF);
    step2(8'h00);
    chk("sens_neg1_x", 32'(x2), 167);
    chk("sens_y", 32'(y2), 120);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
